// File: rtl/muldiv_pkg.sv
//------------------------------------------------------------------------------
// muldiv_pkg
// Shared op encodings, FSM state type and parameter legality constant for
// the iterative multiply/divide unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MADDU = 3'b011;
    localparam logic [2:0] OP_MSUB  = 3'b100;
    localparam logic [2:0] OP_MSUBU = 3'b101;
    localparam logic [2:0] OP_DIV   = 3'b110;
    localparam logic [2:0] OP_DIVU  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bit k set means STEP == k is a supported iteration width.
    localparam logic [4:0] STEP_LEGAL_MASK = 5'b10110;

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_acc(input logic [2:0] op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
//------------------------------------------------------------------------------
// muldiv_step
// One combinational iteration retiring STEP operand bits: shift-add multiply
// or, when DIV_EN is set, restoring shift-subtract divide.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_step #(
    parameter int WIDTH  = 32,
    parameter int STEP   = 1,
    parameter bit DIV_EN = 1'b0
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    generate
        if (DIV_EN) begin : g_muldiv
            always_comb begin
                logic [WIDTH-1:0] hi;
                logic [WIDTH-1:0] lo;
                logic [WIDTH:0]   sh;
                hi = i_hi;
                lo = i_lo;
                sh = '0;
                for (int k = 0; k < STEP; k++) begin
                    if (i_div) begin
                        // hi holds the partial remainder, lo shifts dividend out and quotient in
                        sh = {hi, lo[WIDTH-1]};
                        lo = {lo[WIDTH-2:0], 1'b0};
                        if (sh >= {1'b0, i_b}) begin
                            sh    = sh - {1'b0, i_b};
                            lo[0] = 1'b1;
                        end
                        hi = sh[WIDTH-1:0];
                    end else begin
                        sh = {1'b0, hi} + (lo[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
                        lo = {sh[0], lo[WIDTH-1:1]};
                        hi = sh[WIDTH:1];
                    end
                end
                o_hi = hi;
                o_lo = lo;
            end
        end else begin : g_mul
            logic w_unused_div;
            assign w_unused_div = i_div;

            always_comb begin
                logic [WIDTH-1:0] hi;
                logic [WIDTH-1:0] lo;
                logic [WIDTH:0]   sh;
                hi = i_hi;
                lo = i_lo;
                sh = '0;
                for (int k = 0; k < STEP; k++) begin
                    sh = {1'b0, hi} + (lo[0] ? {1'b0, i_b} : {(WIDTH+1){1'b0}});
                    lo = {sh[0], lo[WIDTH-1:1]};
                    hi = sh[WIDTH:1];
                end
                o_hi = hi;
                o_lo = lo;
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
//------------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply / multiply-accumulate / divide unit with {HI,LO} result.
// Divide hardware is present only when MULDIV_DIV_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   opa_i,
    input  logic [WIDTH-1:0]   opb_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] res_o,
    output logic               stallreq_o
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = $clog2(N + 1);

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    generate
        if ((STEP > 4) || (STEP < 1) || !STEP_LEGAL_MASK[STEP] || ((WIDTH % STEP) != 0)) begin : g_bad_param
            $error("muldiv_unit: illegal STEP/WIDTH combination");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_negq;
    logic               r_negr;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_res;

    logic               w_start;
    logic               w_div_op;
    logic               w_illegal;
    logic               w_div0;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_final;
    logic [2*WIDTH-1:0] w_acc_res;

    assign w_start   = (r_state == ST_IDLE) && start_i && !annul_i;
    assign w_div_op  = is_div(op_i);
    assign w_illegal = w_div_op && !DIV_EN;
    assign w_div0    = w_div_op && DIV_EN && (opb_i == '0);
    assign w_signed  = ~op_i[0];
    assign w_a_neg   = w_signed && opa_i[WIDTH-1];
    assign w_b_neg   = w_signed && opb_i[WIDTH-1];
    assign w_a_mag   = w_a_neg ? -opa_i : opa_i;
    assign w_b_mag   = w_b_neg ? -opb_i : opb_i;

    muldiv_step #(
        .WIDTH  (WIDTH),
        .STEP   (STEP),
        .DIV_EN (DIV_EN)
    ) u_step (
        .i_div (is_div(r_op)),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .i_b   (r_b),
        .o_hi  (w_step_hi),
        .o_lo  (w_step_lo)
    );

    // Multiply results negate as a whole; divide fixes quotient and remainder signs separately.
    assign w_mag     = {r_hi, r_lo};
    assign w_prod    = r_negq ? -w_mag : w_mag;
    assign w_quo     = r_negq ? -r_lo : r_lo;
    assign w_rem     = r_negr ? -r_hi : r_hi;
    assign w_final   = (DIV_EN && is_div(r_op)) ? {w_rem, w_quo} : w_prod;
    assign w_acc_res = r_op[2] ? (r_acc - w_prod) : (r_acc + w_prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next = (w_illegal || w_div0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (annul_i) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_next = is_acc(r_op) ? ST_ACC : ST_DONE;
                end
            end
            ST_ACC:  w_next = annul_i ? ST_IDLE : ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (r_state != ST_IDLE);
        done_o     = (r_state == ST_DONE) && !annul_i;
        stallreq_o = (w_start && !w_illegal) || (r_state == ST_CALC) || (r_state == ST_ACC);
        res_o      = (r_state == ST_DONE) ? w_final : r_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
            r_cnt  <= '0;
            r_res  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_op  <= op_i;
                        r_acc <= acc_i;
                        r_b   <= w_b_mag;
                        r_hi  <= '0;
                        r_cnt <= CNT_W'(N - 1);
                        if (w_illegal || w_div0) begin
                            r_lo   <= '0;
                            r_negq <= 1'b0;
                            r_negr <= 1'b0;
                        end else begin
                            r_lo   <= w_a_mag;
                            r_negq <= w_a_neg ^ w_b_neg;
                            r_negr <= w_a_neg;
                        end
                    end
                end
                ST_CALC: begin
                    r_hi  <= w_step_hi;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_ACC: begin
                    // Result is stored already signed, so DONE must not negate again.
                    {r_hi, r_lo} <= w_acc_res;
                    r_negq       <= 1'b0;
                end
                ST_DONE: begin
                    if (!annul_i) begin
                        r_res <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
